// File: rtl/udp_evt_sync_hub.sv
// udp_evt_sync_hub: per-channel CDC event counters with round-robin delivery.
// Optional feature: define UDP_EVT_TIMESTAMP_EN to add the evt_ts grant stamp.
module udp_evt_sync_hub #(
    parameter int N_CH        = 4,
    parameter int CH_W        = 2,
    parameter int CNT_W       = 4,
    parameter int SYNC_STAGES = 2
`ifdef UDP_EVT_TIMESTAMP_EN
    ,
    parameter int TS_W        = 16
`endif
) (
    input  logic            SNN_CLK,
    input  logic            udp_tx_done_clr,
    input  logic [N_CH-1:0] src_clk,
    input  logic [N_CH-1:0] src_evt,
    input  logic            evt_ready,
    input  logic [N_CH-1:0] ovf_clr,
`ifdef UDP_EVT_TIMESTAMP_EN
    output logic [TS_W-1:0] evt_ts,
`endif
    output logic            evt_valid,
    output logic [CH_W-1:0] evt_ch,
    output logic [N_CH-1:0] evt_pend,
    output logic [N_CH-1:0] evt_ovf
);

    typedef enum logic {S_IDLE, S_PRESENT} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [N_CH-1:0] src_tog;

    logic [N_CH-1:0][SYNC_STAGES-1:0] sync_q, sync_d;
    logic [N_CH-1:0]                  hist_q, hist_d;
    logic [N_CH-1:0]                  inc_q, inc_d;
    logic [N_CH-1:0][CNT_W-1:0]       cnt_q, cnt_d;
    logic [N_CH-1:0]                  pend_q, pend_d;
    logic [N_CH-1:0]                  ovf_q, ovf_d;
    logic [N_CH-1:0]                  nz;
    logic [N_CH-1:0]                  dec;

    state_t          state_q, state_d;
    logic            valid_q, valid_d;
    logic [CH_W-1:0] ch_q, ch_d;
    logic [CH_W-1:0] rr_ptr_q, rr_ptr_d;
    logic            found;
    logic [CH_W-1:0] grant;
    logic [CH_W-1:0] idx;
    int              sum;

    // Source side: each event flips a level that survives the crossing.
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_src
        logic tog_q, tog_d;

        // Next toggle level for this channel.
        always_comb tog_d = tog_q ^ src_evt[gi];

        // Toggle register in the channel's own clock domain.
        always_ff @(posedge src_clk[gi] or posedge udp_tx_done_clr) begin
            if (udp_tx_done_clr) tog_q <= 1'b0;
            else                 tog_q <= tog_d;
        end

        assign src_tog[gi] = tog_q;
    end

    // Synchronizer shift, edge history and registered one-cycle increment.
    always_comb begin
        sync_d = sync_q;
        hist_d = hist_q;
        inc_d  = '0;
        for (int i = 0; i < N_CH; i++) begin
            sync_d[i] = {sync_q[i][SYNC_STAGES-2:0], src_tog[i]};
            hist_d[i] = sync_q[i][SYNC_STAGES-1];
            inc_d[i]  = sync_q[i][SYNC_STAGES-1] ^ hist_q[i];
        end
    end

    // Pending counters: saturate and flag overflow rather than wrap.
    always_comb begin
        cnt_d  = cnt_q;
        ovf_d  = ovf_q & ~ovf_clr;
        pend_d = '0;
        nz     = '0;
        for (int i = 0; i < N_CH; i++) begin
            nz[i] = (cnt_q[i] != '0);
            if (inc_q[i] && !dec[i]) begin
                if (cnt_q[i] == CNT_MAX) ovf_d[i] = 1'b1;
                else cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end else if (!inc_q[i] && dec[i]) begin
                cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end
            pend_d[i] = (cnt_d[i] != '0);
        end
    end

    // Round-robin search starting at rr_ptr, wrapping by compare.
    always_comb begin
        found = 1'b0;
        grant = '0;
        idx   = '0;
        sum   = 0;
        for (int k = 0; k < N_CH; k++) begin
            sum = int'(rr_ptr_q) + k;
            if (sum >= N_CH) sum = sum - N_CH;
            idx = CH_W'(sum);
            if (!found && nz[idx]) begin
                found = 1'b1;
                grant = idx;
            end
        end
    end

    // Presentation FSM: grant in idle, hold until accepted.
    always_comb begin
        state_d  = state_q;
        valid_d  = valid_q;
        ch_d     = ch_q;
        rr_ptr_d = rr_ptr_q;
        dec      = '0;
        unique case (state_q)
            S_IDLE: begin
                valid_d = 1'b0;
                if (found) begin
                    valid_d = 1'b1;
                    ch_d    = grant;
                    state_d = S_PRESENT;
                end
            end
            S_PRESENT: begin
                if (evt_ready) begin
                    dec[ch_q] = 1'b1;
                    valid_d   = 1'b0;
                    rr_ptr_d  = (ch_q == CH_W'(N_CH - 1)) ?
                                '0 : ch_q + CH_W'(1);
                    state_d   = S_IDLE;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Destination-domain state registers.
    always_ff @(posedge SNN_CLK or posedge udp_tx_done_clr) begin
        if (udp_tx_done_clr) begin
            sync_q   <= '0;
            hist_q   <= '0;
            inc_q    <= '0;
            cnt_q    <= '0;
            pend_q   <= '0;
            ovf_q    <= '0;
            state_q  <= S_IDLE;
            valid_q  <= 1'b0;
            ch_q     <= '0;
            rr_ptr_q <= '0;
        end else begin
            sync_q   <= sync_d;
            hist_q   <= hist_d;
            inc_q    <= inc_d;
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
            ovf_q    <= ovf_d;
            state_q  <= state_d;
            valid_q  <= valid_d;
            ch_q     <= ch_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

`ifdef UDP_EVT_TIMESTAMP_EN
    logic [TS_W-1:0] ts_q, ts_d;
    logic [TS_W-1:0] evt_ts_q, evt_ts_d;

    // Free-running stamp, latched when a grant is made.
    always_comb begin
        ts_d     = ts_q + TS_W'(1);
        evt_ts_d = evt_ts_q;
        if (state_q == S_IDLE && found) evt_ts_d = ts_q;
    end

    // Timestamp registers.
    always_ff @(posedge SNN_CLK or posedge udp_tx_done_clr) begin
        if (udp_tx_done_clr) begin
            ts_q     <= '0;
            evt_ts_q <= '0;
        end else begin
            ts_q     <= ts_d;
            evt_ts_q <= evt_ts_d;
        end
    end

    assign evt_ts = evt_ts_q;
`endif

    assign evt_valid = valid_q;
    assign evt_ch    = ch_q;
    assign evt_pend  = pend_q;
    assign evt_ovf   = ovf_q;

endmodule

// File: tb/tb_udp_evt_sync_hub.sv
// tb_udp_evt_sync_hub: scoreboard bench for the CDC event hub.
// Expected channels are queued at stimulus time and popped at each handshake.
module tb_udp_evt_sync_hub;

    localparam int N_CH = 4;
    localparam int CH_W = 2;

    logic            SNN_CLK = 1'b0;
    logic            udp_tx_done_clr = 1'b1;
    logic [N_CH-1:0] src_clk = '0;
    logic [N_CH-1:0] src_evt = '0;
    logic            evt_ready = 1'b0;
    logic [N_CH-1:0] ovf_clr = '0;
    logic            evt_valid;
    logic [CH_W-1:0] evt_ch;
    logic [N_CH-1:0] evt_pend;
    logic [N_CH-1:0] evt_ovf;
`ifdef UDP_EVT_TIMESTAMP_EN
    logic [15:0]     evt_ts;
    logic [15:0]     ts_log[$];
`endif

    int n_chk = 0;
    int n_pass = 0;
    int snn_edges = 0;
    int cap_edge = 0;
    int hs_cnt = 0;
    int base;
    int hs_log[$];
    logic [31:0] exp_q[$];

    udp_evt_sync_hub dut (
        .SNN_CLK(SNN_CLK),
        .udp_tx_done_clr(udp_tx_done_clr),
        .src_clk(src_clk),
        .src_evt(src_evt),
        .evt_ready(evt_ready),
        .ovf_clr(ovf_clr),
`ifdef UDP_EVT_TIMESTAMP_EN
        .evt_ts(evt_ts),
`endif
        .evt_valid(evt_valid),
        .evt_ch(evt_ch),
        .evt_pend(evt_pend),
        .evt_ovf(evt_ovf)
    );

    // 100 MHz destination clock.
    always #5 SNN_CLK = ~SNN_CLK;

    // 125 MHz source clocks, phase-shifted so edges never coincide.
    initial begin
        #2;
        forever #4 src_clk = ~src_clk;
    end

    // Destination edge counter for latency measurement.
    always @(posedge SNN_CLK) snn_edges <= snn_edges + 1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    // Handshake monitor: pop and compare against the scoreboard.
    always @(negedge SNN_CLK) begin
        if (!udp_tx_done_clr && evt_valid && evt_ready) begin
            hs_cnt++;
            hs_log.push_back(snn_edges);
`ifdef UDP_EVT_TIMESTAMP_EN
            ts_log.push_back(evt_ts);
`endif
            if (exp_q.size() == 0) chk("unexp_hs", 1, 0);
            else chk("evt_ch", 32'(evt_ch), exp_q.pop_front());
        end
    end

    task automatic pulse(input logic [N_CH-1:0] m);
        @(posedge src_clk[0]);
        #2 src_evt = m;
        @(posedge src_clk[0]);
        cap_edge = snn_edges;
        #2 src_evt = '0;
    endtask

    task automatic do_reset();
        @(posedge SNN_CLK);
        #1 udp_tx_done_clr = 1'b1;
        repeat (3) @(posedge SNN_CLK);
        #1 udp_tx_done_clr = 1'b0;
        exp_q.delete();
        hs_log.delete();
`ifdef UDP_EVT_TIMESTAMP_EN
        ts_log.delete();
`endif
    endtask

    task automatic wait_valid(input string tag);
        bit seen = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge SNN_CLK);
            seen = evt_valid;
        end
        chk(tag, 32'(seen), 1);
    endtask

    task automatic wait_hs(input string tag, input int target);
        for (int n = 0; n < 400 && hs_cnt < target; n++)
            @(negedge SNN_CLK);
        chk(tag, 32'(hs_cnt >= target), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge SNN_CLK);
        #1 udp_tx_done_clr = 1'b0;
        @(negedge SNN_CLK);
        chk("rst_valid", 32'(evt_valid), 0);
        chk("rst_ch", 32'(evt_ch), 0);
        chk("rst_pend", 32'(evt_pend), 0);
        chk("rst_ovf", 32'(evt_ovf), 0);

        // 1: single pulse on ch2, latency and accept
        exp_q.push_back(2);
        pulse(4'b0100);
        wait_valid("t1_valid");
        chk("t1_lat", 32'(snn_edges - cap_edge), 5);
        chk("t1_pend", 32'(evt_pend), 32'h4);
        @(posedge SNN_CLK);
        #1 evt_ready = 1'b1;
        @(posedge SNN_CLK);
        #1 evt_ready = 1'b0;
        @(negedge SNN_CLK);
        chk("t1_valid_lo", 32'(evt_valid), 0);
        chk("t1_pend_lo", 32'(evt_pend), 0);
        chk("t1_hs", 32'(hs_cnt), 1);

        // 2: all channels at once, ready tied high
        do_reset();
        evt_ready = 1'b1;
        for (int c = 0; c < N_CH; c++) exp_q.push_back(32'(c));
        base = hs_cnt;
        pulse(4'b1111);
        wait_hs("t2_done", base + 4);
        chk("t2_span", 32'(hs_log[3] - hs_log[0]), 6);
        chk("t2_step", 32'(hs_log[1] - hs_log[0]), 2);
`ifdef UDP_EVT_TIMESTAMP_EN
        chk("t2_ts", 32'(16'(ts_log[1] - ts_log[0])), 2);
`endif
        evt_ready = 1'b0;

        // 3: saturation on ch1, drain, overflow clear
        do_reset();
        for (int p = 0; p < 20; p++) begin
            pulse(4'b0010);
            repeat (6) @(posedge SNN_CLK);
        end
        repeat (10) @(posedge SNN_CLK);
        @(negedge SNN_CLK);
        chk("t3_ovf", 32'(evt_ovf), 32'h2);
        chk("t3_pend", 32'(evt_pend), 32'h2);
        chk("t3_valid", 32'(evt_valid), 1);
        chk("t3_ch", 32'(evt_ch), 1);
        for (int p = 0; p < 15; p++) exp_q.push_back(1);
        base = hs_cnt;
        @(posedge SNN_CLK);
        #1 evt_ready = 1'b1;
        wait_hs("t3_drain", base + 15);
        repeat (20) @(negedge SNN_CLK);
        chk("t3_hs", 32'(hs_cnt - base), 15);
        chk("t3_pend_lo", 32'(evt_pend), 0);
        chk("t3_ovf_hold", 32'(evt_ovf), 32'h2);
        @(posedge SNN_CLK);
        #1 begin
            evt_ready = 1'b0;
            ovf_clr = 4'b0010;
        end
        @(posedge SNN_CLK);
        #1 ovf_clr = '0;
        @(negedge SNN_CLK);
        chk("t3_ovf_clr", 32'(evt_ovf), 0);

        // 4: increment and accept on ch0 in the same cycle
        do_reset();
        exp_q.push_back(0);
        exp_q.push_back(0);
        base = hs_cnt;
        pulse(4'b0001);
        wait_valid("t4_valid");
        pulse(4'b0001);
        while (snn_edges < cap_edge + 3) begin
            @(posedge SNN_CLK);
            #1;
        end
        evt_ready = 1'b1;
        @(posedge SNN_CLK);
        #1 evt_ready = 1'b0;
        @(negedge SNN_CLK);
        chk("t4_valid_lo", 32'(evt_valid), 0);
        chk("t4_pend", 32'(evt_pend), 32'h1);
        @(negedge SNN_CLK);
        chk("t4_reassert", 32'(evt_valid), 1);
        @(posedge SNN_CLK);
        #1 evt_ready = 1'b1;
        wait_hs("t4_drain", base + 2);
        repeat (10) @(negedge SNN_CLK);
        chk("t4_hs", 32'(hs_cnt - base), 2);
        chk("t4_pend_lo", 32'(evt_pend), 0);
        evt_ready = 1'b0;

        // 5: reset while presenting discards pending events
        do_reset();
        for (int p = 0; p < 3; p++) begin
            pulse(4'b1000);
            repeat (6) @(posedge SNN_CLK);
        end
        repeat (6) @(posedge SNN_CLK);
        @(negedge SNN_CLK);
        chk("t5_valid", 32'(evt_valid), 1);
        chk("t5_pend", 32'(evt_pend), 32'h8);
        base = hs_cnt;
        @(posedge SNN_CLK);
        #1 udp_tx_done_clr = 1'b1;
        #2;
        chk("t5_rst_valid", 32'(evt_valid), 0);
        chk("t5_rst_pend", 32'(evt_pend), 0);
        repeat (3) @(posedge SNN_CLK);
        #1 begin
            udp_tx_done_clr = 1'b0;
            evt_ready = 1'b1;
        end
        repeat (30) @(negedge SNN_CLK);
        chk("t5_no_hs", 32'(hs_cnt - base), 0);
        chk("t5_idle", 32'(evt_valid), 0);
        exp_q.push_back(3);
        pulse(4'b1000);
        wait_hs("t5_new", base + 1);
        evt_ready = 1'b0;
        repeat (5) @(negedge SNN_CLK);
        chk("t5_q_empty", 32'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
